// File: rtl/mhp_frame_engine.sv
// mhp_frame_engine
//   Frame receive/reply engine between the MAC rx/tx byte FIFOs and the UART
//   debug mirror. One payload is drained into an internal buffer and
//   end-of-frame is detected when rx stays idle for GAP_CYCLES. The reply has
//   the same length, padded up to MIN_LEN entries, and is either an echo of
//   the payload or an all-PAD frame. A free-running tick counter (o_time)
//   optionally holds off the next frame until the tick changes.
//
// Ports
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_mode            reply select latched at end-of-frame (0 echo, 1 all-PAD)
//   i_rdata/i_rready  rx FIFO data (valid the cycle after o_rreq) / non-empty
//   o_rreq            rx FIFO pop strobe
//   i_wready          tx FIFO can accept
//   o_wvalid/o_wdata  tx write strobe / data
//   o_wvalid_u/_wdata_u  UART mirror of the tx write
//   o_done            pulse on the last reply write
//   o_overflow        set when the frame is longer than the buffer
//   o_rx_len          length of the last received frame (saturating)
//   o_frames          completed reply count (wraps)
//   o_time            tick counter
//   o_dbg_state       current FSM state
//
// Handshakes: o_rreq pops one rx byte at the clock edge where it is high; that
// byte is captured one cycle later. A tx entry is transferred in exactly the
// cycle where o_wvalid is high; o_wvalid is never high while i_wready is low,
// and o_wdata is stable for the whole time an entry waits for i_wready.
module mhp_frame_engine #(
  parameter int                DATA_W     = 8,
  parameter int                ADDR_W     = 8,
  parameter int                MIN_LEN    = 48,
  parameter logic [DATA_W-1:0] PAD        = '0,
  parameter int                GAP_CYCLES = 62,
  parameter int                TICK_DIV   = 50000000,
  parameter int                HOLDOFF_EN = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_mode,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic              i_rready,
  output logic              o_rreq,
  input  logic              i_wready,
  output logic              o_wvalid,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_wvalid_u,
  output logic [DATA_W-1:0] o_wdata_u,
  output logic              o_done,
  output logic              o_overflow,
  output logic [ADDR_W:0]   o_rx_len,
  output logic [15:0]       o_frames,
  output logic [31:0]       o_time,
  output logic [2:0]        o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD      = 3'd1,
    S_GAP     = 3'd2,
    S_EOF     = 3'd3,
    S_TX_ADDR = 3'd4,
    S_TX_DATA = 3'd5,
    S_TX_PUT  = 3'd6,
    S_HOLD    = 3'd7
  } state_t;

  localparam int DEPTH   = 1 << ADDR_W;
  // A minimum length beyond the buffer depth is clamped to the depth.
  localparam int MIN_EFF = (MIN_LEN > DEPTH) ? DEPTH : MIN_LEN;
  localparam int GW      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [ADDR_W:0] MIN_V    = (ADDR_W+1)'(MIN_EFF);
  localparam logic [GW-1:0]   GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);

  state_t              state_q, state_d;
  logic [ADDR_W:0]     wptr, rptr, txlen, rptr_inc;
  logic [GW-1:0]       gap_cnt;
  logic [TW-1:0]       tick_cnt;
  logic [31:0]         hold_time;
  logic                mode_q;
  logic [DATA_W-1:0]   rd_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                rreq_c, wvalid_c, done_c, last_put;
  logic [DATA_W-1:0]   mem [DEPTH];

  assign rptr_inc = rptr + (ADDR_W+1)'(1);
  assign last_put = (rptr_inc == txlen);

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and strobes
  always_comb begin
    state_d  = state_q;
    rreq_c   = 1'b0;
    wvalid_c = 1'b0;
    done_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_rready) begin
          rreq_c  = 1'b1;
          state_d = S_RD;
        end
      end
      S_RD: state_d = S_GAP;
      S_GAP: begin
        // A waiting byte wins over the gap timeout in the same cycle.
        if (i_rready) begin
          rreq_c  = 1'b1;
          state_d = S_RD;
        end else if (gap_cnt == GAP_LAST) begin
          state_d = S_EOF;
        end
      end
      S_EOF:     state_d = S_TX_ADDR;
      S_TX_ADDR: state_d = S_TX_DATA;
      S_TX_DATA: state_d = S_TX_PUT;
      S_TX_PUT: begin
        if (i_wready) begin
          wvalid_c = 1'b1;
          if (last_put) begin
            done_c  = 1'b1;
            state_d = (HOLDOFF_EN != 0) ? S_HOLD : S_IDLE;
          end else begin
            state_d = S_TX_ADDR;
          end
        end
      end
      S_HOLD: begin
        if (o_time != hold_time) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and counters
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tick_cnt   <= '0;
      o_time     <= '0;
      wptr       <= '0;
      rptr       <= '0;
      txlen      <= '0;
      gap_cnt    <= '0;
      mode_q     <= 1'b0;
      wdata_q    <= '0;
      hold_time  <= '0;
      o_overflow <= 1'b0;
      o_rx_len   <= '0;
      o_frames   <= '0;
    end else begin
      if (tick_cnt == TICK_LAST) begin
        tick_cnt <= '0;
        o_time   <= o_time + 32'd1;
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end

      case (state_q)
        S_IDLE: begin
          wptr       <= '0;
          gap_cnt    <= '0;
          o_overflow <= 1'b0;
        end
        S_RD: begin
          // wptr[ADDR_W] set means the buffer is full; wptr then sticks there.
          if (wptr[ADDR_W]) o_overflow <= 1'b1;
          else              wptr <= wptr + (ADDR_W+1)'(1);
          gap_cnt <= '0;
        end
        S_GAP: begin
          if (!i_rready) gap_cnt <= gap_cnt + GW'(1);
        end
        S_EOF: begin
          o_rx_len <= wptr;
          mode_q   <= i_mode;
          txlen    <= (wptr > MIN_V) ? wptr : MIN_V;
          rptr     <= '0;
        end
        S_TX_DATA: begin
          wdata_q <= (!mode_q && (rptr < wptr)) ? rd_q : PAD;
        end
        S_TX_PUT: begin
          if (i_wready) begin
            rptr <= rptr_inc;
            if (last_put) begin
              o_frames  <= o_frames + 16'd1;
              hold_time <= o_time;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Payload buffer: synchronous write in RD, synchronous read in TX_ADDR.
  // Since txlen never exceeds the depth, rptr always indexes inside it.
  always_ff @(posedge i_clk) begin
    if (state_q == S_RD && !wptr[ADDR_W]) mem[wptr[ADDR_W-1:0]] <= i_rdata;
    if (state_q == S_TX_ADDR)             rd_q <= mem[rptr[ADDR_W-1:0]];
  end

  // Strobes are gated by reset so every output reads 0 while reset is held.
  assign o_rreq      = rreq_c && !i_rst;
  assign o_wvalid    = wvalid_c;
  assign o_done      = done_c;
  assign o_wdata     = wdata_q;
  assign o_wvalid_u  = wvalid_c;
  assign o_wdata_u   = wdata_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_mhp_frame_engine.sv
module tb_mhp_frame_engine;

  // Clock / reset
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  // Main DUT: depth 256, holdoff enabled, short tick
  logic        i_mode, i_rready, i_wready, o_rreq, o_wvalid, o_wvalid_u, o_done, o_overflow;
  logic [7:0]  i_rdata, o_wdata, o_wdata_u;
  logic [8:0]  o_rx_len;
  logic [15:0] o_frames;
  logic [31:0] o_time;
  logic [2:0]  o_dbg_state;

  // Second DUT: depth 16, holdoff disabled
  logic        i_mode4, i_rready4, i_wready4, o_rreq4, o_wvalid4, o_wvalid_u4, o_done4, o_overflow4;
  logic [7:0]  i_rdata4, o_wdata4, o_wdata_u4;
  logic [4:0]  o_rx_len4;
  logic [15:0] o_frames4;
  logic [31:0] o_time4;
  logic [2:0]  o_dbg_state4;

  mhp_frame_engine #(.DATA_W(8), .ADDR_W(8), .MIN_LEN(48), .PAD(8'h00), .GAP_CYCLES(62),
                     .TICK_DIV(100), .HOLDOFF_EN(1)) u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_mode(i_mode), .i_rdata(i_rdata), .i_rready(i_rready),
    .o_rreq(o_rreq), .i_wready(i_wready), .o_wvalid(o_wvalid), .o_wdata(o_wdata),
    .o_wvalid_u(o_wvalid_u), .o_wdata_u(o_wdata_u), .o_done(o_done), .o_overflow(o_overflow),
    .o_rx_len(o_rx_len), .o_frames(o_frames), .o_time(o_time), .o_dbg_state(o_dbg_state));

  mhp_frame_engine #(.DATA_W(8), .ADDR_W(4), .MIN_LEN(48), .PAD(8'h00), .GAP_CYCLES(62),
                     .TICK_DIV(100), .HOLDOFF_EN(0)) u_dut4 (
    .i_clk(i_clk), .i_rst(i_rst), .i_mode(i_mode4), .i_rdata(i_rdata4), .i_rready(i_rready4),
    .o_rreq(o_rreq4), .i_wready(i_wready4), .o_wvalid(o_wvalid4), .o_wdata(o_wdata4),
    .o_wvalid_u(o_wvalid_u4), .o_wdata_u(o_wdata_u4), .o_done(o_done4), .o_overflow(o_overflow4),
    .o_rx_len(o_rx_len4), .o_frames(o_frames4), .o_time(o_time4), .o_dbg_state(o_dbg_state4));

  // Scoreboard state: each entry is {last, data}
  logic [8:0]  exp_q[$];
  logic [8:0]  exp4_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          pops4 = 0;
  logic [31:0] t_done = '0;
  logic        prev_rreq = 1'b0;
  logic        prev_rreq4 = 1'b0;
  logic        wr_toggle = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic bound_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // tx FIFO readiness: always ready, or toggling every cycle
  always @(negedge i_clk) begin
    if (wr_toggle) i_wready = ~i_wready;
    else           i_wready = 1'b1;
  end

  // Monitor: pops and compares on every tx write, checks mirror and rx strobe
  always @(negedge i_clk) begin
    logic [8:0] e;
    #1;
    if (!i_rst) begin
      if (o_wvalid_u !== o_wvalid || o_wdata_u !== o_wdata)
        chk("uart_mirror", {23'd0, o_wvalid_u, o_wdata_u}, {23'd0, o_wvalid, o_wdata});
      if (o_wvalid) begin
        chk("wvalid_needs_wready", {31'd0, i_wready}, 32'd1);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: data 0x%0h with no expected entry", o_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("tx_data", {24'd0, o_wdata}, {24'd0, e[7:0]});
          chk("tx_done", {31'd0, o_done}, {31'd0, e[8]});
          if (o_done) t_done = o_time;
        end
      end else if (o_done) begin
        chk("done_without_write", {31'd0, o_done}, 32'd0);
      end
      if (o_wvalid4) begin
        if (exp4_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write4: data 0x%0h with no expected entry", o_wdata4);
        end else begin
          e = exp4_q.pop_front();
          chk("tx4_data", {24'd0, o_wdata4}, {24'd0, e[7:0]});
          chk("tx4_done", {31'd0, o_done4}, {31'd0, e[8]});
        end
      end
      if (o_rreq && prev_rreq)   chk("rreq_back_to_back", 32'd1, 32'd0);
      if (o_rreq4 && prev_rreq4) chk("rreq4_back_to_back", 32'd1, 32'd0);
    end
    prev_rreq  = o_rreq;
    prev_rreq4 = o_rreq4;
  end

  // Driver: offer one byte and wait (bounded) for the pop; returns o_time and
  // o_frames as seen in the pop cycle.
  task automatic push_byte(input bit d4, input logic [7:0] b,
                           output logic [31:0] t_at, output logic [15:0] f_at);
    int w = 0;
    t_at = '0;
    f_at = '0;
    forever begin
      @(negedge i_clk);
      if (d4) i_rready4 = 1'b1; else i_rready = 1'b1;
      #1;
      if ((d4 ? o_rreq4 : o_rreq) === 1'b1) break;
      w++;
      if (w > 3000) begin
        bound_fail("rx_pop_timeout");
        break;
      end
    end
    t_at = d4 ? o_time4 : o_time;
    f_at = d4 ? o_frames4 : o_frames;
    if (d4) begin
      i_rdata4 = b;
      pops4++;
    end else begin
      i_rdata = b;
    end
    @(negedge i_clk);
    if (d4) i_rready4 = 1'b0; else i_rready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  // Sends bytes base, base+1, ...; after byte index gap_after, rx idles gap_len cycles.
  task automatic send_frame(input bit d4, input int n, input logic [7:0] base,
                            input int gap_after, input int gap_len,
                            output logic [31:0] t_first, output logic [15:0] f_first);
    logic [31:0] t;
    logic [15:0] f;
    t_first = '0;
    f_first = '0;
    for (int i = 0; i < n; i++) begin
      push_byte(d4, base + 8'(i), t, f);
      if (i == 0) begin
        t_first = t;
        f_first = f;
      end
      if (i == gap_after) idle(gap_len);
    end
  endtask

  // Expected reply: stored payload bytes (echo) or PAD, txlen entries, last flagged.
  task automatic exp_frame(input bit d4, input int n, input logic [7:0] base,
                           input bit mode, input int txlen);
    logic [7:0] d;
    for (int k = 0; k < txlen; k++) begin
      d = (!mode && k < n) ? base + 8'(k) : 8'h00;
      if (d4) exp4_q.push_back({k == txlen - 1, d});
      else    exp_q.push_back({k == txlen - 1, d});
    end
  endtask

  task automatic wait_drain();
    int w = 0;
    while ((exp_q.size() != 0 || exp4_q.size() != 0) && w < 5000) begin
      @(negedge i_clk);
      w++;
    end
    if (w >= 5000) bound_fail("tx_drain");
    idle(4);
  endtask

  initial begin
    logic [31:0] t;
    logic [15:0] f;
    int w;
    i_mode = 1'b0; i_rdata = '0; i_rready = 1'b0; i_wready = 1'b1;
    i_mode4 = 1'b0; i_rdata4 = '0; i_rready4 = 1'b0; i_wready4 = 1'b1;

    // Reset values
    idle(3);
    #1;
    chk("rst_rreq", {31'd0, o_rreq}, 32'd0);
    chk("rst_wvalid", {31'd0, o_wvalid}, 32'd0);
    chk("rst_wdata", {24'd0, o_wdata}, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    chk("rst_overflow", {31'd0, o_overflow}, 32'd0);
    chk("rst_rx_len", {23'd0, o_rx_len}, 32'd0);
    chk("rst_frames", {16'd0, o_frames}, 32'd0);
    chk("rst_time", o_time, 32'd0);
    chk("rst_state", {29'd0, o_dbg_state}, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;

    // A: 10 bytes 0x01..0x0A, echo, padded to 48
    i_mode = 1'b0;
    exp_frame(0, 10, 8'h01, 1'b0, 48);
    send_frame(0, 10, 8'h01, -1, 0, t, f);
    idle(70);

    // B: 5 bytes with a 61-cycle hole after byte 2, offered while A still
    // transmits; first pop must wait for A's reply and the next tick.
    wr_toggle = 1'b1;
    exp_frame(0, 5, 8'h20, 1'b0, 48);
    send_frame(0, 5, 8'h20, 1, 61, t, f);
    chk("b_first_pop_frames", {16'd0, f}, 32'd1);
    chk("b_holdoff_time_changed", {31'd0, t != t_done}, 32'd1);
    chk("a_rx_len", {23'd0, o_rx_len}, 32'd10);
    idle(70);
    chk("b_rx_len", {23'd0, o_rx_len}, 32'd5);

    // C: 60 bytes, all-PAD reply of exactly 60 entries
    i_mode = 1'b1;
    exp_frame(0, 60, 8'h40, 1'b1, 60);
    send_frame(0, 60, 8'h40, -1, 0, t, f);
    chk("c_first_pop_frames", {16'd0, f}, 32'd2);
    idle(70);
    i_mode = 1'b0;
    chk("c_rx_len", {23'd0, o_rx_len}, 32'd60);
    wait_drain();
    chk("c_frames", {16'd0, o_frames}, 32'd3);
    chk("c_overflow", {31'd0, o_overflow}, 32'd0);

    // D: reset in the middle of the reply
    wr_toggle = 1'b0;
    exp_frame(0, 10, 8'h60, 1'b0, 48);
    send_frame(0, 10, 8'h60, -1, 0, t, f);
    idle(70);
    w = 0;
    while (exp_q.size() > 40 && w < 3000) begin
      @(negedge i_clk);
      w++;
    end
    if (w >= 3000) bound_fail("d_tx_start");
    @(negedge i_clk);
    #2;
    i_rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_wvalid", {31'd0, o_wvalid}, 32'd0);
    chk("midrst_wvalid_u", {31'd0, o_wvalid_u}, 32'd0);
    chk("midrst_wdata", {24'd0, o_wdata}, 32'd0);
    chk("midrst_done", {31'd0, o_done}, 32'd0);
    chk("midrst_frames", {16'd0, o_frames}, 32'd0);
    chk("midrst_rx_len", {23'd0, o_rx_len}, 32'd0);
    chk("midrst_time", o_time, 32'd0);
    chk("midrst_state", {29'd0, o_dbg_state}, 32'd0);
    idle(3);
    i_rst = 1'b0;
    idle(200);  // abandoned reply must not resume

    // E: depth-16 engine, 20-byte frame overflows, reply 1..16
    i_mode4 = 1'b0;
    exp_frame(1, 16, 8'h01, 1'b0, 16);
    send_frame(1, 20, 8'h01, -1, 0, t, f);
    idle(70);
    chk("e_overflow", {31'd0, o_overflow4}, 32'd1);
    chk("e_rx_len", {27'd0, o_rx_len4}, 32'd16);
    chk("e_pops", 32'(pops4), 32'd20);
    wait_drain();
    chk("e_frames", {16'd0, o_frames4}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
